// File: rtl/btn_pkg.sv
// Shared types and default timing for the front-panel button conditioner.
// Holds the channel FSM encoding and counter-width helpers.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEB_P = 2'd1,
        HELD  = 2'd2,
        DEB_R = 2'd3
    } btn_state_t;

    localparam int DEF_N           = 4;
    localparam int DEF_TICK_CYC    = 1000;
    localparam int DEF_DEBOUNCE_MS = 20;
    localparam int DEF_LONG_MS     = 500;
    localparam int DEF_REP_SLOW_MS = 100;
    localparam int DEF_REP_FAST_MS = 50;
    localparam int DEF_FAST_AFTER  = 8;
    localparam int DEF_ACTIVE_LOW  = 0;

    // Bits needed to hold 0..maxv, never less than one.
    function automatic int cnt_w(input int maxv);
        return (maxv < 1) ? 1 : $clog2(maxv + 1);
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_repeat_ch.sv
// One button channel: synchroniser, debounce FSM, hold timing.
// All timing advances on the shared ms tick; pulses are registered.
module btn_repeat_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int LONG_MS     = DEF_LONG_MS,
    parameter int REP_SLOW_MS = DEF_REP_SLOW_MS,
    parameter int REP_FAST_MS = DEF_REP_FAST_MS,
    parameter int FAST_AFTER  = DEF_FAST_AFTER,
    parameter int ACTIVE_LOW  = DEF_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tick,
    input  logic btn_in,
    output logic level,
    output logic press,
    output logic release_p,
    output logic long_p,
    output logic repeat_p
);

    localparam int DW = cnt_w(DEBOUNCE_MS);
    localparam int HW = cnt_w(max_i(LONG_MS, REP_SLOW_MS));
    localparam int RW = cnt_w(FAST_AFTER);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] LONG_V   = HW'(LONG_MS);
    localparam logic [HW-1:0] SLOW_V   = HW'(REP_SLOW_MS);
    localparam logic [HW-1:0] FAST_V   = HW'(REP_FAST_MS);
    localparam logic [RW-1:0] FAST_N   = RW'(FAST_AFTER);

    logic s1;
    logic s2;
    logic s;

    btn_state_t state;
    btn_state_t state_n;

    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_n;
    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_n;
    logic [HW-1:0] pcnt;
    logic [HW-1:0] pcnt_n;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_n;

    logic [HW-1:0] h_inc;
    logic [HW-1:0] p_inc;
    logic [HW-1:0] period;

    logic lvl_n;
    logic press_n;
    logic rel_n;
    logic long_n;
    logic rep_n;

    // Two-flop synchroniser; keeps running while en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
        end
    end

    assign s = (ACTIVE_LOW != 0) ? ~s2 : s2;

    assign h_inc  = hcnt + 1'b1;
    assign p_inc  = pcnt + 1'b1;
    assign period = (rcnt == FAST_N) ? FAST_V : SLOW_V;

    // Next state, counters and pulse requests
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        hcnt_n  = hcnt;
        pcnt_n  = pcnt;
        rcnt_n  = rcnt;
        press_n = 1'b0;
        rel_n   = 1'b0;
        long_n  = 1'b0;
        rep_n   = 1'b0;

        if (!en) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s) begin
                        state_n = DEB_P;
                        dcnt_n  = '0;
                    end
                end
                DEB_P: begin
                    if (!s) begin
                        state_n = IDLE;
                    end else if (tick) begin
                        if (dcnt == DEB_LAST) begin
                            state_n = HELD;
                            press_n = 1'b1;
                            hcnt_n  = '0;
                            pcnt_n  = '0;
                            rcnt_n  = '0;
                        end else begin
                            dcnt_n = dcnt + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_n = DEB_R;
                        dcnt_n  = '0;
                    end else if (tick) begin
                        if (hcnt != LONG_V) begin
                            hcnt_n = h_inc;
                            long_n = (h_inc == LONG_V);
                        end else if (p_inc == period) begin
                            pcnt_n = '0;
                            rep_n  = 1'b1;
                            if (rcnt != FAST_N) begin
                                rcnt_n = rcnt + 1'b1;
                            end
                        end else begin
                            pcnt_n = p_inc;
                        end
                    end
                end
                DEB_R: begin
                    if (s) begin
                        state_n = HELD;
                    end else if (tick) begin
                        if (dcnt == DEB_LAST) begin
                            state_n = IDLE;
                            rel_n   = 1'b1;
                        end else begin
                            dcnt_n = dcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        lvl_n = (state_n == HELD) || (state_n == DEB_R);
    end

    // FSM and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dcnt  <= '0;
            hcnt  <= '0;
            pcnt  <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
            hcnt  <= hcnt_n;
            pcnt  <= pcnt_n;
            rcnt  <= rcnt_n;
        end
    end

    // Registered level and one-clock pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= 1'b0;
            press     <= 1'b0;
            release_p <= 1'b0;
            long_p    <= 1'b0;
            repeat_p  <= 1'b0;
        end else begin
            level     <= lvl_n;
            press     <= press_n;
            release_p <= rel_n;
            long_p    <= long_n;
            repeat_p  <= rep_n;
        end
    end

endmodule

// File: rtl/btn_repeat_bank.sv
// N-channel push-button conditioner with long-press and auto-repeat.
// One shared ms prescaler drives every channel's timing.
module btn_repeat_bank
    import btn_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int TICK_CYC    = DEF_TICK_CYC,
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int LONG_MS     = DEF_LONG_MS,
    parameter int REP_SLOW_MS = DEF_REP_SLOW_MS,
    parameter int REP_FAST_MS = DEF_REP_FAST_MS,
    parameter int FAST_AFTER  = DEF_FAST_AFTER,
    parameter int ACTIVE_LOW  = DEF_ACTIVE_LOW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_p,
    output logic [N-1:0] long_p,
    output logic [N-1:0] repeat_p
);

    localparam int PW = cnt_w(TICK_CYC - 1);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_CYC - 1);

    logic [PW-1:0] pcnt;
    logic          tick;

    assign tick = (pcnt == P_LAST);

    // Free-running ms prescaler, independent of en
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        btn_repeat_ch #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .REP_SLOW_MS (REP_SLOW_MS),
            .REP_FAST_MS (REP_FAST_MS),
            .FAST_AFTER  (FAST_AFTER),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .tick      (tick),
            .btn_in    (btn_in[g]),
            .level     (level[g]),
            .press     (press[g]),
            .release_p (release_p[g]),
            .long_p    (long_p[g]),
            .repeat_p  (repeat_p[g])
        );
    end

endmodule

// File: tb/tb_btn_repeat_bank.sv
// Bench for btn_repeat_bank with a 4-cycle ms tick.
// Per-cycle model check plus table vectors and timing sequences.
module tb_btn_repeat_bank;

    localparam int N    = 4;
    localparam int TICK = 4;
    localparam int DEB  = 20;
    localparam int LONG = 500;
    localparam int SLOW = 100;
    localparam int FAST = 50;
    localparam int FA   = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] btn_in;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] release_p;
    logic [N-1:0] long_p;
    logic [N-1:0] repeat_p;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    always #5 clk = ~clk;

    btn_repeat_bank #(
        .N           (N),
        .TICK_CYC    (TICK),
        .DEBOUNCE_MS (DEB),
        .LONG_MS     (LONG),
        .REP_SLOW_MS (SLOW),
        .REP_FAST_MS (FAST),
        .FAST_AFTER  (FA),
        .ACTIVE_LOW  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .btn_in    (btn_in),
        .level     (level),
        .press     (press),
        .release_p (release_p),
        .long_p    (long_p),
        .repeat_p  (repeat_p)
    );

    // reference model state
    logic [N-1:0] m_s1 = '0;
    logic [N-1:0] m_s2 = '0;
    logic [N-1:0] m_prev = '0;
    logic [N-1:0] m_lvl = '0;
    logic [N-1:0] e_pr = '0;
    logic [N-1:0] e_rl = '0;
    logic [N-1:0] e_lg = '0;
    logic [N-1:0] e_rp = '0;
    int m_cnt[N];
    int m_h[N];
    int m_pc = 0;

    // event log
    int n_pr[N];
    int n_rl[N];
    int n_lg[N];
    int n_rp[N];
    int t_pr[N];
    int t_rl[N];
    int t_lg[N];
    int rp_q[$];

    typedef struct {
        int ch;
        int hold_ms;
        int e_pr;
        int e_rl;
        int e_lg;
        int e_rp;
    } vec_t;

    vec_t tbl[5];
    int rexp[14];

    // repeat instants as total hold time in ticks
    function automatic bit rep_at(input int h);
        int x;
        x = h - LONG;
        if (x <= 0) return 1'b0;
        if (x <= FA * SLOW) return (x % SLOW) == 0;
        return ((x - FA * SLOW) % FAST) == 0;
    endfunction

    task automatic model_edge();
        bit tk;
        bit s;
        tk = (m_pc == TICK - 1);
        e_pr = '0;
        e_rl = '0;
        e_lg = '0;
        e_rp = '0;
        if (rst) begin
            m_pc = 0;
            m_s1 = '0;
            m_s2 = '0;
            m_prev = '0;
            m_lvl = '0;
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0;
                m_h[i] = 0;
            end
            return;
        end
        m_pc = (m_pc + 1) % TICK;
        for (int i = 0; i < N; i++) begin
            s = m_s2[i];
            if (!en) begin
                m_lvl[i] = 1'b0;
                m_cnt[i] = 0;
                m_prev[i] = 1'b0;
            end else if (s != m_lvl[i]) begin
                if (m_prev[i] == m_lvl[i]) begin
                    m_cnt[i] = 0;
                end else if (tk) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DEB) begin
                        m_cnt[i] = 0;
                        m_lvl[i] = s;
                        if (s) begin
                            e_pr[i] = 1'b1;
                            m_h[i] = 0;
                        end else begin
                            e_rl[i] = 1'b1;
                        end
                    end
                end
                m_prev[i] = s;
            end else begin
                m_cnt[i] = 0;
                if (m_lvl[i] && m_prev[i] && tk) begin
                    m_h[i]++;
                    if (m_h[i] == LONG) e_lg[i] = 1'b1;
                    if (rep_at(m_h[i])) e_rp[i] = 1'b1;
                end
                m_prev[i] = s;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic clr_log();
        for (int i = 0; i < N; i++) begin
            n_pr[i] = 0;
            n_rl[i] = 0;
            n_lg[i] = 0;
            n_rp[i] = 0;
            t_pr[i] = 0;
            t_rl[i] = 0;
            t_lg[i] = 0;
        end
        rp_q.delete();
    endtask

    task automatic cyc();
        logic [5*N-1:0] got;
        logic [5*N-1:0] want;
        @(posedge clk);
        model_edge();
        ncyc++;
        @(negedge clk);
        got  = {level, press, release_p, long_p, repeat_p};
        want = {m_lvl, e_pr, e_rl, e_lg, e_rp};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL model cyc=%0d got=%h want=%h", ncyc, got, want);
        end
        for (int i = 0; i < N; i++) begin
            if (press[i] === 1'b1) begin
                n_pr[i]++;
                t_pr[i] = ncyc;
            end
            if (release_p[i] === 1'b1) begin
                n_rl[i]++;
                t_rl[i] = ncyc;
            end
            if (long_p[i] === 1'b1) begin
                n_lg[i]++;
                t_lg[i] = ncyc;
            end
            if (repeat_p[i] === 1'b1) begin
                n_rp[i]++;
                if (i == 0) rp_q.push_back(ncyc);
            end
        end
    endtask

    task automatic wait_ms(input int ms);
        repeat (ms * TICK) cyc();
    endtask

    task automatic wait_press(input int ch);
        int k;
        k = 0;
        while (n_pr[ch] == 0 && k < 200) begin
            cyc();
            k++;
        end
        if (n_pr[ch] == 0) chk("press timeout", 0, 1);
    endtask

    task automatic wait_until(input int c);
        while (ncyc < c) cyc();
    endtask

    int t0;
    int tp;
    int tr;

    initial begin
        rst = 1'b1;
        en = 1'b1;
        btn_in = '0;
        clr_log();
        tbl[0] = '{0, 10, 0, 0, 0, 0};
        tbl[1] = '{1, 30, 1, 1, 0, 0};
        tbl[2] = '{2, 540, 1, 1, 1, 0};
        tbl[3] = '{3, 650, 1, 1, 1, 1};
        tbl[4] = '{1, 800, 1, 1, 1, 2};
        rexp = '{600, 700, 800, 900, 1000, 1100, 1200, 1300,
                 1350, 1400, 1450, 1500, 1550, 1600};

        repeat (3) cyc();
        chk("reset outs", int'({level, press, release_p, long_p, repeat_p}), 0);
        rst = 1'b0;
        wait_ms(5);

        // clean short press on ch0
        clr_log();
        btn_in[0] = 1'b1;
        t0 = ncyc;
        wait_ms(30);
        chk("t1 level", int'(level[0]), 1);
        btn_in[0] = 1'b0;
        tr = ncyc;
        wait_ms(30);
        chk("t1 npress", n_pr[0], 1);
        chk_rng("t1 press lat", t_pr[0] - t0, DEB * TICK, DEB * TICK + 3);
        chk("t1 nrel", n_rl[0], 1);
        chk_rng("t1 rel lat", t_rl[0] - tr, DEB * TICK, DEB * TICK + 3);
        chk("t1 nlong", n_lg[0], 0);

        // bouncing ch1
        clr_log();
        for (int k = 0; k < 8; k++) begin
            btn_in[1] = ~btn_in[1];
            wait_ms(5);
        end
        btn_in[1] = 1'b1;
        t0 = ncyc;
        wait_ms(30);
        chk("t2 npress", n_pr[1], 1);
        chk_rng("t2 press lat", t_pr[1] - t0, DEB * TICK, DEB * TICK + 3);
        chk("t2 nrel", n_rl[1], 0);
        btn_in[1] = 1'b0;
        wait_ms(30);

        // long hold with slow then fast repeats
        clr_log();
        btn_in[0] = 1'b1;
        wait_press(0);
        tp = t_pr[0];
        wait_until(tp + 1605 * TICK);
        btn_in[0] = 1'b0;
        wait_ms(30);
        chk("t3 nlong", n_lg[0], 1);
        chk("t3 long at", t_lg[0] - tp, LONG * TICK);
        chk("t3 nrep", rp_q.size(), 14);
        for (int k = 0; k < 14; k++) begin
            if (k < rp_q.size()) chk("t3 rep at", rp_q[k] - tp, rexp[k] * TICK);
        end

        // simultaneous press on ch0 and ch3
        clr_log();
        btn_in[0] = 1'b1;
        btn_in[3] = 1'b1;
        wait_press(0);
        cyc();
        tp = t_pr[0];
        chk("t4 same press", t_pr[3], tp);
        wait_until(tp + 300 * TICK);
        btn_in[3] = 1'b0;
        wait_until(tp + 520 * TICK);
        chk("t4 ch0 long at", t_lg[0] - tp, LONG * TICK);
        chk("t4 ch3 nrel", n_rl[3], 1);
        chk("t4 ch3 nlong", n_lg[3], 0);
        btn_in[0] = 1'b0;
        wait_ms(30);

        // reset during hold on ch2
        clr_log();
        btn_in[2] = 1'b1;
        wait_press(2);
        tp = t_pr[2];
        wait_until(tp + 700 * TICK);
        clr_log();
        rst = 1'b1;
        cyc();
        tr = ncyc;
        chk("t5 outs after rst", int'({level, press, release_p, long_p, repeat_p}), 0);
        rst = 1'b0;
        wait_ms(25);
        chk("t5 npress", n_pr[2], 1);
        chk("t5 repress at", t_pr[2] - tr, DEB * TICK);
        chk("t5 nrel", n_rl[2], 0);
        btn_in[2] = 1'b0;
        wait_ms(30);

        // short glitch during DEB_R of a long hold
        clr_log();
        btn_in[0] = 1'b1;
        wait_press(0);
        tp = t_pr[0];
        wait_until(tp + 650 * TICK);
        btn_in[0] = 1'b0;
        wait_ms(3);
        btn_in[0] = 1'b1;
        wait_until(tp + 760 * TICK);
        chk("t6 nrel", n_rl[0], 0);
        chk("t6 nrep", rp_q.size(), 2);
        if (rp_q.size() == 2) begin
            chk("t6 rep0 at", rp_q[0] - tp, 600 * TICK);
            chk_rng("t6 rep1 gap", rp_q[1] - rp_q[0], SLOW * TICK + 8, SLOW * TICK + 20);
        end
        btn_in[0] = 1'b0;
        wait_ms(30);

        // en drop while held
        clr_log();
        btn_in[1] = 1'b1;
        wait_press(1);
        cyc();
        en = 1'b0;
        cyc();
        chk("en off level", int'(level[1]), 0);
        wait_ms(5);
        en = 1'b1;
        wait_ms(25);
        chk("en npress", n_pr[1], 2);
        chk("en nrel", n_rl[1], 0);
        btn_in[1] = 1'b0;
        wait_ms(30);

        // table vectors
        for (int v = 0; v < 5; v++) begin
            clr_log();
            btn_in[tbl[v].ch] = 1'b1;
            wait_ms(tbl[v].hold_ms);
            btn_in[tbl[v].ch] = 1'b0;
            wait_ms(30);
            chk($sformatf("vec%0d press", v), n_pr[tbl[v].ch], tbl[v].e_pr);
            chk($sformatf("vec%0d rel", v), n_rl[tbl[v].ch], tbl[v].e_rl);
            chk($sformatf("vec%0d long", v), n_lg[tbl[v].ch], tbl[v].e_lg);
            chk($sformatf("vec%0d rep", v), n_rp[tbl[v].ch], tbl[v].e_rp);
        end

        // random stimulus against the model
        for (int it = 0; it < 200; it++) begin
            btn_in = btn_in ^ N'($urandom);
            en = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
            end
            if ($urandom_range(0, 31) == 0) begin
                wait_ms(650);
            end else begin
                repeat ($urandom_range(1, 120)) cyc();
            end
        end
        en = 1'b1;
        btn_in = '0;
        wait_ms(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
